nco_cfg_sequencer: RTL and testbench
====================================

Name: nco_cfg_sequencer

Overview:
- Sits between the I2C configuration slave outputs (enable, wave, frequency, duty_cycle) and the NCO phase-accumulator/waveform datapath.
- Detects new configurations, waits for them to be stable, then applies them atomically on a phase-accumulator wrap, so an active waveform never glitches mid-period.
- Forces the update if no wrap arrives within a timeout.
- Issues an accumulator-clear pulse when the NCO is being enabled.

Parameters:
- FREQ_W, 64, width of frequency tuning word.
- DUTY_W, 16, width of duty-cycle word.
- SETTLE_CYCLES, 4, consecutive stable cycles required before a new config is accepted (>=1).
- TIMEOUT, 1024, max cycles spent waiting for phase_wrap before a forced apply (>=2).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_enable  in  1  requested enable from config slave.
- cfg_wave  in  2  requested waveform select.
- cfg_frequency  in  FREQ_W  requested tuning word.
- cfg_duty_cycle  in  DUTY_W  requested duty cycle.
- phase_wrap  in  1  one-cycle pulse from NCO when the phase accumulator overflows.
- nco_enable  out  1  applied enable.
- nco_wave  out  2  applied waveform select.
- nco_frequency  out  FREQ_W  applied tuning word.
- nco_duty_cycle  out  DUTY_W  applied duty cycle.
- acc_clear  out  1  one-cycle pulse; clears the phase accumulator.
- busy  out  1  high whenever state != IDLE.
- update_count  out  8  number of applies performed; wraps 255->0.
- timeout_flag  out  1  sticky; set by any forced apply.

Behaviour:

Reset (rst=1 at clk edge):
- state=IDLE.
- All nco_* outputs 0; acc_clear 0; busy 0; update_count 0; timeout_flag 0.
- Internal pending regs, settle counter and timeout counter cleared.
- rst has priority over all events, including mid-WAIT_WRAP (pending config is discarded).

Definitions:
- "cfg" = concatenation {cfg_enable, cfg_wave, cfg_frequency, cfg_duty_cycle}.
- "applied" = the same concatenation of nco_* outputs.
- "pend" = internal copy of cfg.
- cfg inputs are synchronous to clk; no synchronizers are used.

States:
- IDLE: if cfg != applied -> pend<=cfg, settle_cnt<=0, go SETTLE. Otherwise stay.
- SETTLE:
  - If cfg != pend -> pend<=cfg, settle_cnt<=0, stay (restart).
  - Else if cfg == applied (request reverted) -> go IDLE with no apply.
  - Else settle_cnt++.
  - When settle_cnt reaches SETTLE_CYCLES-1 with cfg stable: if nco_enable==0 go APPLY; else go WAIT_WRAP with tmo_cnt<=0.
- WAIT_WRAP:
  - pend is frozen; cfg changes are ignored here and picked up in IDLE after the apply.
  - phase_wrap=1 -> go APPLY.
  - Else if tmo_cnt==TIMEOUT-1 -> timeout_flag<=1, go APPLY.
  - Else tmo_cnt++.
  - phase_wrap in the same cycle as the timeout terminal count counts as a wrap: flag not set.
  - phase_wrap is sampled from the first WAIT_WRAP cycle.
- APPLY (exactly one cycle):
  - nco_* <= pend, all fields in the same edge.
  - update_count++.
  - acc_clear=1 in this cycle iff nco_enable==0 and pend.enable==1 (combinational from state).
  - Next state IDLE.

Other rules:
- Disabling (1->0) follows the normal path: waits for wrap, so the final period completes.
- phase_wrap outside WAIT_WRAP is ignored.
- Latency while NCO is disabled, default params: cfg change visible at edge E -> nco_* updated at edge E+SETTLE_CYCLES+2 (6 clocks).
- acc_clear is never high outside APPLY.

Test Plan:
- Reset, then cfg={1,2'b01,64'h10,16'h8000}, no phase_wrap -> 6 clocks later nco_* equal cfg; acc_clear pulses 1 cycle in APPLY; update_count=1; busy high for 5 cycles.
- NCO enabled; change cfg_frequency to 64'h20; pulse phase_wrap 10 cycles after SETTLE ends -> nco_frequency changes on the edge after the wrap; no acc_clear; timeout_flag=0.
- NCO enabled; change cfg_duty_cycle; no phase_wrap -> forced apply after TIMEOUT=1024 WAIT_WRAP cycles; timeout_flag=1 and remains 1 after further normal updates.
- Toggle cfg_frequency every 2 cycles for 20 cycles, then hold 64'h55 -> exactly one apply with 64'h55; update_count +1 only; no intermediate values on nco_frequency.
- In WAIT_WRAP, change cfg_wave 2'b01->2'b10, then phase_wrap -> first apply uses pend value 2'b01; IDLE then detects 2'b10 and a second apply follows (update_count +2).
- Assert rst during WAIT_WRAP -> next cycle all outputs 0 and busy=0; a subsequent phase_wrap causes no apply.

Source files
------------

// File: rtl/nco_cfg_sequencer.sv
// NCO configuration sequencer.
// Captures a changed configuration, waits until it has been stable for
// SETTLE_CYCLES, then applies it in one edge. When the NCO is running the
// apply waits for a phase wrap so that no period is cut short. If the wrap
// does not come within TIMEOUT cycles the apply is forced anyway.
module nco_cfg_sequencer #(
    parameter int FREQ_W        = 64,
    parameter int DUTY_W        = 16,
    parameter int SETTLE_CYCLES = 4,
    parameter int TIMEOUT       = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_enable,
    input  logic [1:0]        cfg_wave,
    input  logic [FREQ_W-1:0] cfg_frequency,
    input  logic [DUTY_W-1:0] cfg_duty_cycle,
    input  logic              phase_wrap,
    output logic              nco_enable,
    output logic [1:0]        nco_wave,
    output logic [FREQ_W-1:0] nco_frequency,
    output logic [DUTY_W-1:0] nco_duty_cycle,
    output logic              acc_clear,
    output logic              busy,
    output logic [7:0]        update_count,
    output logic              timeout_flag
);

    localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int TCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);
    localparam logic [TCW-1:0] TMO_LAST    = TCW'(TIMEOUT - 1);

    typedef struct packed {
        logic              enable;
        logic [1:0]        wave;
        logic [FREQ_W-1:0] frequency;
        logic [DUTY_W-1:0] duty;
    } cfg_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SETTLE    = 2'd1,
        WAIT_WRAP = 2'd2,
        APPLY     = 2'd3
    } state_t;

    state_t         state;
    cfg_t           req;
    cfg_t           applied;
    cfg_t           pend;
    logic [SCW-1:0] settle_cnt;
    logic [TCW-1:0] tmo_cnt;

    assign req     = {cfg_enable, cfg_wave, cfg_frequency, cfg_duty_cycle};
    assign applied = {nco_enable, nco_wave, nco_frequency, nco_duty_cycle};

    // Clear pulse only when an apply turns a stopped NCO on.
    assign acc_clear = (state == APPLY) && !nco_enable && pend.enable;
    assign busy      = (state != IDLE);

    // Sequencer FSM: capture, settle, wait for wrap, apply.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            pend           <= '0;
            settle_cnt     <= '0;
            tmo_cnt        <= '0;
            nco_enable     <= 1'b0;
            nco_wave       <= '0;
            nco_frequency  <= '0;
            nco_duty_cycle <= '0;
            update_count   <= '0;
            timeout_flag   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req != applied) begin
                        pend       <= req;
                        settle_cnt <= '0;
                        state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (req != pend) begin
                        // Still moving: restart the stability window.
                        pend       <= req;
                        settle_cnt <= '0;
                    end else if (req == applied) begin
                        // Request went back to what is already applied.
                        state <= IDLE;
                    end else if (settle_cnt == SETTLE_LAST) begin
                        if (!nco_enable) begin
                            state <= APPLY;
                        end else begin
                            tmo_cnt <= '0;
                            state   <= WAIT_WRAP;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                WAIT_WRAP: begin
                    // A wrap on the terminal count wins over the timeout.
                    if (phase_wrap) begin
                        state <= APPLY;
                    end else if (tmo_cnt == TMO_LAST) begin
                        timeout_flag <= 1'b1;
                        state        <= APPLY;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                APPLY: begin
                    nco_enable     <= pend.enable;
                    nco_wave       <= pend.wave;
                    nco_frequency  <= pend.frequency;
                    nco_duty_cycle <= pend.duty;
                    update_count   <= update_count + 8'd1;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nco_cfg_sequencer.sv
// Directed bench for nco_cfg_sequencer with default parameters.
module tb_nco_cfg_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_enable;
    logic [1:0]  cfg_wave;
    logic [63:0] cfg_frequency;
    logic [15:0] cfg_duty_cycle;
    logic        phase_wrap;
    logic        nco_enable;
    logic [1:0]  nco_wave;
    logic [63:0] nco_frequency;
    logic [15:0] nco_duty_cycle;
    logic        acc_clear;
    logic        busy;
    logic [7:0]  update_count;
    logic        timeout_flag;

    int total = 0;
    int bad   = 0;
    int busy_n;

    always #5 clk = ~clk;

    nco_cfg_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_enable     (cfg_enable),
        .cfg_wave       (cfg_wave),
        .cfg_frequency  (cfg_frequency),
        .cfg_duty_cycle (cfg_duty_cycle),
        .phase_wrap     (phase_wrap),
        .nco_enable     (nco_enable),
        .nco_wave       (nco_wave),
        .nco_frequency  (nco_frequency),
        .nco_duty_cycle (nco_duty_cycle),
        .acc_clear      (acc_clear),
        .busy           (busy),
        .update_count   (update_count),
        .timeout_flag   (timeout_flag)
    );

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs are driven and outputs sampled 1 ns later.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wrap_pulse();
        phase_wrap = 1'b1;
        tick();
        phase_wrap = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cfg_enable = 1'b0; cfg_wave = 2'b00;
        cfg_frequency = '0; cfg_duty_cycle = '0; phase_wrap = 1'b0;
        tick(2);
        rst = 1'b0;

        // Reset state
        chk("rst_en",    nco_enable, 0);
        chk("rst_freq",  nco_frequency, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_cnt",   update_count, 0);
        chk("rst_tmo",   timeout_flag, 0);
        chk("rst_clr",   acc_clear, 0);
        tick(2);
        chk("idle_busy", busy, 0);

        // 1: enable from disabled, applies 6 edges later with acc_clear
        cfg_enable = 1'b1; cfg_wave = 2'b01; cfg_frequency = 64'h10; cfg_duty_cycle = 16'h8000;
        busy_n = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (busy) busy_n++;
            if (i < 4) chk("t1_noclr", acc_clear, 0);
        end
        chk("t1_clr",    acc_clear, 1);
        chk("t1_pre_en", nco_enable, 0);
        tick();
        if (busy) busy_n++;
        chk("t1_busy_n", busy_n, 5);
        chk("t1_cfg", {nco_enable, nco_wave, nco_frequency, nco_duty_cycle},
                      {1'b1, 2'b01, 64'h10, 16'h8000});
        chk("t1_clr_off", acc_clear, 0);
        chk("t1_cnt",     update_count, 1);

        // 2: running, apply on wrap 10 cycles after settle
        tick();
        cfg_frequency = 64'h20;
        tick(5);
        chk("t2_wait_busy", busy, 1);
        tick(10);
        chk("t2_hold", nco_frequency, 64'h10);
        wrap_pulse();
        chk("t2_apply_clr", acc_clear, 0);
        chk("t2_apply_hold", nco_frequency, 64'h10);
        tick();
        chk("t2_freq", nco_frequency, 64'h20);
        chk("t2_cnt",  update_count, 2);
        chk("t2_tmo",  timeout_flag, 0);
        chk("t2_busy", busy, 0);

        // 3: no wrap, forced apply after 1024 waiting cycles
        tick();
        cfg_duty_cycle = 16'h4000;
        tick(5);
        tick(1023);
        chk("t3_pre_tmo",  timeout_flag, 0);
        chk("t3_pre_duty", nco_duty_cycle, 16'h8000);
        chk("t3_pre_busy", busy, 1);
        tick();
        chk("t3_tmo", timeout_flag, 1);
        tick();
        chk("t3_duty", nco_duty_cycle, 16'h4000);
        chk("t3_cnt",  update_count, 3);

        // 4: unstable frequency never applies; final stable value does once
        tick();
        for (int i = 0; i < 10; i++) begin
            cfg_frequency = (i % 2 == 0) ? 64'h30 : 64'h40;
            tick(2);
            chk("t4_noglitch", nco_frequency, 64'h20);
        end
        cfg_frequency = 64'h55;
        tick(5);
        chk("t4_hold", nco_frequency, 64'h20);
        chk("t4_hold_cnt", update_count, 3);
        wrap_pulse();
        tick();
        chk("t4_freq",   nco_frequency, 64'h55);
        chk("t4_cnt",    update_count, 4);
        chk("t4_sticky", timeout_flag, 1);

        // 5: wave change during wait is deferred to a second apply
        tick();
        cfg_frequency = 64'h66;
        tick(5);
        chk("t5_wait", busy, 1);
        cfg_wave = 2'b10;
        tick(2);
        wrap_pulse();
        tick();
        chk("t5_freq1", nco_frequency, 64'h66);
        chk("t5_wave1", nco_wave, 2'b01);
        chk("t5_cnt1",  update_count, 5);
        tick(5);
        chk("t5_wait2", busy, 1);
        chk("t5_hold2", nco_wave, 2'b01);
        wrap_pulse();
        tick();
        chk("t5_wave2", nco_wave, 2'b10);
        chk("t5_cnt2",  update_count, 6);

        // 6: reset during wait discards pend; later wrap does nothing
        tick();
        cfg_frequency = 64'h77;
        tick(5);
        chk("t6_wait", busy, 1);
        rst = 1'b1;
        cfg_enable = 1'b0; cfg_wave = 2'b00; cfg_frequency = '0; cfg_duty_cycle = '0;
        tick();
        rst = 1'b0;
        chk("t6_out", {nco_enable, nco_wave, nco_frequency, nco_duty_cycle}, 96'h0);
        chk("t6_busy", busy, 0);
        chk("t6_cnt",  update_count, 0);
        chk("t6_tmo",  timeout_flag, 0);
        wrap_pulse();
        tick(3);
        chk("t6_nowrap_cnt",  update_count, 0);
        chk("t6_nowrap_busy", busy, 0);
        chk("t6_nowrap_freq", nco_frequency, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
